// File: rtl/unidade_busca.sv
// Instruction-fetch unit: fetches over a req/ready handshake, issues one instruction
// at a time to the decoder and computes the next PC (sequential, beq-taken, j).
module unidade_busca #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [5:0]  OPcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        stall,
  output logic [31:0] retired
);

  typedef enum logic {StFetch, StIssue} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_active;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;

  logic        w_fetch_done;
  logic        w_issue_done;
  logic        w_is_jump;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_offset_shifted;
  logic [31:0] w_next_pc;

  assign w_pc_plus4       = r_pc + 32'd4;
  assign w_offset_shifted = branch_offset << 2;
  assign w_is_jump        = (r_instr[31:26] == 6'b000010);

  // r_active keeps the request low until the first edge after reset is released.
  assign w_fetch_done = (r_state == StFetch) && r_active && imem_ready;
  assign w_issue_done = (r_state == StIssue) && !stall;

  always_comb begin
    if (w_is_jump) begin
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (branch && zero) begin
      w_next_pc = w_pc_plus4 + w_offset_shifted;
    end else begin
      w_next_pc = w_pc_plus4;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFetch: if (w_fetch_done) w_state_next = StIssue;
      StIssue: if (!stall)       w_state_next = StFetch;
      default: w_state_next = StFetch;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (r_state)
      StFetch: imem_req    = r_active;
      StIssue: instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0;
      r_retired <= 32'h0;
    end else begin
      r_active <= 1'b1;
      if (w_fetch_done) begin
        r_instr <= imem_data;
      end
      if (w_issue_done) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign instr     = r_instr;
  assign OPcode    = r_instr[31:26];
  assign retired   = r_retired;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: memory model with programmable wait states, a scoreboard of
// expected issued (pc, instr) pairs, and one task per scenario.
module tb_unidade_busca;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [5:0]  OPcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        zero;
  logic [31:0] branch_offset;
  logic        stall;
  logic [31:0] retired;

  unidade_busca #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_data(imem_data), .instr(instr), .OPcode(OPcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .branch(branch), .zero(zero),
    .branch_offset(branch_offset), .stall(stall), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } issue_t;

  issue_t      sb[$];
  logic [31:0] mem [logic [31:0]];
  int          waits = 0;
  int          wcnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        prev_valid = 1'b0;

  // Memory model: answers a held request after `waits` wait-state cycles.
  always @(negedge clock) begin
    if (imem_req) begin
      if (wcnt >= waits) begin
        imem_ready = 1'b1;
        imem_data  = mem.exists(imem_addr) ? mem[imem_addr] : 32'h0;
      end else begin
        imem_ready = 1'b0;
        imem_data  = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      imem_ready = 1'b0;
      imem_data  = 32'hDEAD_BEEF;
      wcnt       = 0;
    end
  end

  // Scoreboard: each new issue must match the oldest expected (pc, instr).
  always @(negedge clock) begin
    issue_t e;
    if (!reset && instr_valid && !prev_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL issue_unexpected: got pc=%h instr=%h, required no issue", pc, instr);
      end else begin
        e = sb.pop_front();
        if (pc !== e.pc || instr !== e.instr || OPcode !== e.instr[31:26]) begin
          $display("FAIL issue: got pc=%h instr=%h op=%h, required pc=%h instr=%h",
                   pc, instr, OPcode, e.pc, e.instr);
        end else begin
          n_pass++;
        end
      end
    end
    prev_valid = instr_valid;
  end

  task automatic expect_issue(input logic [31:0] a, input logic [31:0] d);
    mem[a] = d;
    sb.push_back({a, d});
  endtask

  // Waits for the next issue, applies decoder inputs and lets it retire.
  task automatic issue_one(input logic br, input logic z, input logic [31:0] off,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    branch = br; zero = z; branch_offset = off; stall = 1'b0;
    @(posedge clock);
    #1;
    branch = 1'b0; zero = 1'b0; branch_offset = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0; branch_offset = 32'h0;
    imem_ready = 1'b0; imem_data = 32'h0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || retired !== 32'h0 || instr_valid !== 1'b0
        || imem_req !== 1'b0)
      $display("FAIL reset_state: pc=%h instr=%h ret=%0d valid=%b req=%b, required all 0",
               pc, instr, retired, instr_valid, imem_req);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL first_req: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_sequential;
    bit ok;
    expect_issue(32'h0, 32'h8C08_0004);
    expect_issue(32'h4, 32'h0000_0000);
    issue_one(1'b0, 1'b0, 32'h0, ok);
    @(negedge clock);
    n_checks++;
    if (!ok || instr_valid !== 1'b0 || imem_addr !== 32'h4 || retired !== 32'd1)
      $display("FAIL seq_first: ok=%b valid=%b addr=%h ret=%0d, required 1 0 00000004 1",
               ok, instr_valid, imem_addr, retired);
    else n_pass++;
    issue_one(1'b0, 1'b0, 32'h0, ok);
    @(negedge clock);
    n_checks++;
    if (!ok || retired !== 32'd2 || imem_addr !== 32'h8)
      $display("FAIL seq_second: ok=%b ret=%0d addr=%h, required 1 2 00000008",
               ok, retired, imem_addr);
    else n_pass++;
  endtask

  task automatic test_branch;
    bit ok;
    expect_issue(32'h8, 32'h0800_0004);
    expect_issue(32'h10, 32'h1000_FFFF);
    issue_one(1'b0, 1'b0, 32'h0, ok);
    issue_one(1'b1, 1'b1, 32'hFFFF_FFFC, ok);
    @(negedge clock);
    n_checks++;
    if (!ok || imem_addr !== 32'h4)
      $display("FAIL beq_taken: ok=%b addr=%h, required 1 00000004", ok, imem_addr);
    else n_pass++;
    sb.push_back({32'h4, 32'h0});
    sb.push_back({32'h8, 32'h0800_0004});
    sb.push_back({32'h10, 32'h1000_FFFF});
    issue_one(1'b0, 1'b0, 32'h0, ok);
    issue_one(1'b0, 1'b0, 32'h0, ok);
    issue_one(1'b1, 1'b0, 32'hFFFF_FFFC, ok);
    @(negedge clock);
    n_checks++;
    if (!ok || imem_addr !== 32'h14 || retired !== 32'd7)
      $display("FAIL beq_not_taken: ok=%b addr=%h ret=%0d, required 1 00000014 7",
               ok, imem_addr, retired);
    else n_pass++;
  endtask

  task automatic test_jump;
    bit ok;
    expect_issue(32'h14, 32'h1000_0000);
    expect_issue(32'h4000_0020, 32'h0800_0100);
    issue_one(1'b1, 1'b1, 32'h1000_0002, ok);
    @(negedge clock);
    n_checks++;
    if (!ok || imem_addr !== 32'h4000_0020 || retired !== 32'd8)
      $display("FAIL far_branch: ok=%b addr=%h ret=%0d, required 1 40000020 8",
               ok, imem_addr, retired);
    else n_pass++;
    // branch/zero asserted on a j: the jump must win.
    issue_one(1'b1, 1'b1, 32'h0000_0040, ok);
    @(negedge clock);
    n_checks++;
    if (!ok || imem_addr !== 32'h4000_0400 || retired !== 32'd9)
      $display("FAIL jump: ok=%b addr=%h ret=%0d, required 1 40000400 9",
               ok, imem_addr, retired);
    else n_pass++;
  endtask

  task automatic test_wait_states;
    bit ok;
    int bad = 0;
    expect_issue(32'h4000_0400, 32'h2000_0000);
    waits = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0400 || instr_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL wait_hold: bad cycles=%0d, required 0 (req=%b addr=%h valid=%b)",
               bad, imem_req, imem_addr, instr_valid);
    else n_pass++;
    issue_one(1'b0, 1'b0, 32'h0, ok);
    waits = 0;
    @(negedge clock);
    n_checks++;
    if (!ok || imem_addr !== 32'h4000_0404 || retired !== 32'd10)
      $display("FAIL wait_issue: ok=%b addr=%h ret=%0d, required 1 40000404 10",
               ok, imem_addr, retired);
    else n_pass++;
  endtask

  task automatic test_stall;
    bit ok = 1'b0;
    int vc = 0;
    int bad = 0;
    expect_issue(32'h4000_0404, 32'h1000_0003);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (instr_valid) vc++;
    stall = 1'b1; branch = 1'b1; zero = 1'b1; branch_offset = 32'h100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      if (instr_valid) vc++;
      if (pc !== 32'h4000_0404 || retired !== 32'd10) bad++;
      branch = ~branch; zero = ~zero;
    end
    stall = 1'b0; branch = 1'b0; zero = 1'b1;
    @(posedge clock);
    #1;
    zero = 1'b0; branch_offset = 32'h0;
    @(negedge clock);
    n_checks++;
    if (!ok || vc != 3 || bad != 0)
      $display("FAIL stall_hold: ok=%b valid_cycles=%0d bad=%0d, required 1 3 0", ok, vc, bad);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h4000_0408 || retired !== 32'd11 || instr_valid !== 1'b0)
      $display("FAIL stall_release: addr=%h ret=%0d valid=%b, required 40000408 11 0",
               imem_addr, retired, instr_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch;
    bit ok;
    expect_issue(32'h4000_0408, 32'h1000_0001);
    issue_one(1'b1, 1'b1, 32'h2FFF_FF05, ok);
    waits = 100;
    repeat (2) @(negedge clock);
    n_checks++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 32'h20)
      $display("FAIL pre_reset_fetch: ok=%b req=%b addr=%h, required 1 1 00000020",
               ok, imem_req, imem_addr);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (pc !== 32'h0 || retired !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0)
      $display("FAIL async_reset: pc=%h ret=%0d instr=%h valid=%b, required 0 0 0 0",
               pc, retired, instr, instr_valid);
    else n_pass++;
    waits = 0;
    @(negedge clock);
    reset = 1'b0;
    sb.push_back({32'h0, 32'h8C08_0004});
    issue_one(1'b0, 1'b0, 32'h0, ok);
    @(negedge clock);
    n_checks++;
    if (!ok || retired !== 32'd1 || imem_addr !== 32'h4)
      $display("FAIL restart: ok=%b ret=%0d addr=%h, required 1 1 00000004",
               ok, retired, imem_addr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wait_states();
    test_stall();
    test_reset_mid_fetch();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
Instruction-fetch unit for the MIPS datapath. It is the producer side of the opcode interface: it fetches instructions from instruction memory over a req/ready handshake, holds each in an instruction register, and presents OPcode/instr to the control decoder and datapath. It consumes the decoder's branch result (branch, zero) and computes the next PC, including sequential, beq-taken and j paths.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  instruction-memory read request
imem_addr  out  32  word-aligned fetch address (= pc)
imem_ready  in  1  memory has valid imem_data this cycle
imem_data  in  32  fetched instruction word
instr  out  32  instruction register contents
OPcode  out  6  instr[31:26], to control decoder
instr_valid  out  1  instr is valid and being issued this cycle
pc  out  32  address of the current instruction
pc_plus4  out  32  pc + 4
branch  in  1  decoder branch output (beq); sampled only on issue
zero  in  1  ALU zero flag; sampled only on issue
branch_offset  in  32  sign-extended immediate; sampled only on issue
stall  in  1  hold the current instruction in ISSUE
retired  out  32  count of issued (completed) instructions

Behaviour:
- Reset (async, any state/cycle): pc=RESET_PC, instr=0, state=FETCH, retired=0, instr_valid=0. imem_req becomes 1 from the first edge after reset deasserts. An in-flight fetch is abandoned. Memory must tolerate a dropped request.
- States: FETCH, ISSUE (2-state FSM).
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On a clock edge with imem_ready=1: instr<=imem_data, go to ISSUE.
  - With imem_ready=0: stay in FETCH and keep req/addr stable. Wait states are unbounded.
- ISSUE:
  - imem_req=0, instr_valid=1. OPcode, instr, pc and pc_plus4 are stable.
  - imem_ready is ignored outside FETCH.
  - stall=1: stay in ISSUE with instr_valid held high. Nothing is updated and branch/zero are not sampled.
  - stall=0: on the edge, pc<=next_pc, retired<=retired+1, go to FETCH.
- next_pc priority:
  1. OPcode==6'b000010 (j): {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. branch & zero: pc_plus4 + (branch_offset << 2), low 32 bits.
  3. Otherwise: pc_plus4.
- Arithmetic: all 32-bit modular. pc wraps from 32'hFFFF_FFFC to 0 with no flag. retired wraps at 2^32.
- Throughput: 2 cycles per instruction with zero-wait memory (imem_ready=1 in the first FETCH cycle); +1 cycle per wait state and per stall cycle.
- Outputs are registered or decoded from state only. There is no combinational path from imem_data to OPcode.
- branch with zero=0 gives the sequential path. branch=1 on a j opcode is overridden by the jump.

Test Plan:
- Reset then zero-wait memory returning 32'h8C08_0004 (lw) then 32'h0000_0000 → imem_addr 0 then 4; OPcode 6'h23 then 6'h00; instr_valid high 1 cycle each; retired=2 after 4 cycles.
- beq at pc=0x10, branch=1, zero=1, branch_offset=32'hFFFF_FFFC → next imem_addr=0x04. Repeat with zero=0 → next imem_addr=0x14.
- j at pc=0x4000_0020 with instr=32'h0800_0100 → next imem_addr=0x4000_0400; retired increments by 1.
- imem_ready held low 3 cycles in FETCH → imem_req/imem_addr stable for 4 cycles, instr_valid=0 throughout; then normal issue.
- stall=1 for 2 cycles in ISSUE with branch toggling → instr_valid high 3 cycles, pc unchanged; only branch/zero values at the stall=0 edge affect next_pc; retired +1 once.
- Assert reset mid-FETCH while waiting on memory at pc=0x20 → pc=RESET_PC, retired=0, instr=0 immediately (async); fetch restarts at RESET_PC after release.
